vram_arbiter: RTL

Two-requester arbiter that shares the single 16-bit VRAM port between the graphite rasterizer (requester 1) and the display scan-out / host port (requester 0). It sits between the graphite core's VRAM master signals and the VRAM controller. It serialises accesses with round-robin fairness, registers every memory-side output, returns read data, and aborts any access whose acknowledge never arrives.

---
 rtl/graphite_vram_pkg.sv | 16 +
 rtl/vram_rr_pick.sv | 22 ++
 rtl/vram_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/graphite_vram_pkg.sv
// Shared types and constants for the graphite VRAM arbiter.
// Requester 0 is scan-out/host, requester 1 is the rasterizer.
package graphite_vram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } vram_arb_state_t;

    localparam logic REQ_HOST = 1'b0;
    localparam logic REQ_GFX  = 1'b1;

    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/vram_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to the requester that was not granted last.
module vram_rr_pick
    import graphite_vram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt,
    output logic       vld
);

    always_comb begin
        vld = |req;
        gnt = REQ_HOST;
        if (req == 2'b11) begin
            gnt = ~last_grant;
        end else if (req[1]) begin
            gnt = REQ_GFX;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Serialises host/scan-out and rasterizer accesses onto the single VRAM port
// with round-robin fairness, registered memory-side outputs and an ack timeout.
module vram_arbiter
    import graphite_vram_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MASK_W  = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_i,

    input  logic              m0_req_i,
    input  logic              m0_wr_i,
    input  logic [MASK_W-1:0] m0_mask_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [DATA_W-1:0] m0_data_o,

    input  logic              m1_req_i,
    input  logic              m1_wr_i,
    input  logic [MASK_W-1:0] m1_mask_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [DATA_W-1:0] m1_data_o,

    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [MASK_W-1:0] vram_mask_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    output logic [DATA_W-1:0] vram_data_out_o,
    input  logic [DATA_W-1:0] vram_data_in_i,
    input  logic              vram_ack_i,

    output logic              busy_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    vram_arb_state_t   state;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic              grant;

    logic              pick_gnt;
    logic              pick_vld;
    logic              pick_wr;
    logic [MASK_W-1:0] pick_mask;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_data;

    logic              access_end;
    logic              access_err;
    logic [DATA_W-1:0] done_data;

    vram_rr_pick u_pick (
        .req        ({m1_req_i, m0_req_i}),
        .last_grant (last_grant),
        .gnt        (pick_gnt),
        .vld        (pick_vld)
    );

    always_comb begin
        pick_wr   = m0_wr_i;
        pick_mask = m0_mask_i;
        pick_addr = m0_addr_i;
        pick_data = m0_data_i;
        if (pick_gnt == REQ_GFX) begin
            pick_wr   = m1_wr_i;
            pick_mask = m1_mask_i;
            pick_addr = m1_addr_i;
            pick_data = m1_data_i;
        end
    end

    // An ack on the last counted cycle still wins over the abort.
    assign access_end = vram_ack_i || (cnt == CNT_LAST);
    assign access_err = ~vram_ack_i;
    assign done_data  = vram_ack_i ? vram_data_in_i : '0;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state           <= IDLE;
            cnt             <= '0;
            last_grant      <= REQ_GFX;
            grant           <= REQ_HOST;
            vram_sel_o      <= 1'b0;
            vram_wr_o       <= 1'b0;
            vram_mask_o     <= '0;
            vram_addr_o     <= '0;
            vram_data_out_o <= '0;
            m0_ack_o        <= 1'b0;
            m0_err_o        <= 1'b0;
            m0_data_o       <= '0;
            m1_ack_o        <= 1'b0;
            m1_err_o        <= 1'b0;
            m1_data_o       <= '0;
            busy_o          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant           <= pick_gnt;
                        last_grant      <= pick_gnt;
                        vram_sel_o      <= 1'b1;
                        vram_wr_o       <= pick_wr;
                        vram_mask_o     <= pick_mask;
                        vram_addr_o     <= pick_addr;
                        vram_data_out_o <= pick_data;
                        cnt             <= '0;
                        busy_o          <= 1'b1;
                        state           <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (access_end) begin
                        vram_sel_o <= 1'b0;
                        state      <= DONE;
                        if (grant == REQ_GFX) begin
                            m1_ack_o  <= 1'b1;
                            m1_err_o  <= access_err;
                            m1_data_o <= done_data;
                        end else begin
                            m0_ack_o  <= 1'b1;
                            m0_err_o  <= access_err;
                            m0_data_o <= done_data;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Requests are not looked at here, so a req still high from
                // before the ack pulse cannot win a second grant.
                DONE: begin
                    m0_ack_o  <= 1'b0;
                    m0_err_o  <= 1'b0;
                    m0_data_o <= '0;
                    m1_ack_o  <= 1'b0;
                    m1_err_o  <= 1'b0;
                    m1_data_o <= '0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
